upc_checkout_ctrl: RTL and testbench
====================================

Name: upc_checkout_ctrl

Overview:
- Checkout-lane sequencer built around the UPC classifier equations.
- Accepts scanned items over a valid/ready handshake and classifies each one as sale, stolen or normal.
- Keeps per-transaction item and sale counts.
- Locks the lane with a latched alarm on a stolen item until an attendant clears it, then closes the transaction on a checkout request.

Parameters:
CW, 8, width of item_count and sale_count; both counters saturate at 2^CW-1.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
item_valid  input  1  scanner presents an item this cycle
upc  input  3  item code; upc[2]=U, upc[1]=P, upc[0]=C
mark  input  1  item marked as sold/paid
item_ready  output  1  controller can accept an item this cycle
checkout  input  1  request to close the current transaction
clear_alarm  input  1  attendant acknowledge; releases an alarm lock
item_count  output  CW  non-stolen items accepted in current/last transaction
sale_count  output  CW  sale items among item_count
alarm  output  1  stolen item detected; lane locked
busy  output  1  a transaction is open (state SCAN or ALARM)
txn_done  output  1  one-cycle pulse when a transaction closes

Behaviour:
- Classification, combinational on the accepted item: sale = P | (U & C); stolen = ~mark & ~P & (U | ~C).
- Accept: an item is accepted when item_valid & item_ready on a rising clk edge. upc and mark are sampled only at accept.
- Reset (async, active-high): state IDLE; item_count=0, sale_count=0, alarm=0, txn_done=0, busy=0. item_ready=1 once reset deasserts.
- States: IDLE, SCAN, ALARM, DONE. Outputs are registered or decoded from state; no combinational path from item_valid to item_ready.
- IDLE: item_ready=1, busy=0. checkout and clear_alarm are ignored.
  - Accepted non-stolen item: item_count:=1, sale_count:=sale, go to SCAN.
  - Accepted stolen item: item_count:=0, sale_count:=0, alarm:=1, go to ALARM.
  - Counts from the previous transaction stay visible in IDLE until the first accept.
- SCAN: item_ready=1, busy=1.
  - Accepted non-stolen item: item_count+1 and sale_count+sale, each saturating at 2^CW-1.
  - Accepted stolen item: counts unchanged, alarm:=1, go to ALARM.
  - checkout=1 with no stolen accept in the same cycle: go to DONE. A non-stolen item accepted in that same cycle is counted first.
  - Stolen accept and checkout in the same cycle: ALARM wins and checkout is dropped.
- ALARM: item_ready=0, alarm=1, busy=1. checkout is ignored and item_valid is held off by ready=0.
  - clear_alarm=1: alarm:=0, go to SCAN; counts retained.
- DONE: lasts exactly one cycle. txn_done=1, item_ready=0, busy=0, counts held. Then go to IDLE unconditionally.
- Latency: an accept updates counts and alarm on the same edge, so they are visible the next cycle. checkout in SCAN produces txn_done in the next cycle.
- Invariant: sale_count <= item_count at all times, including under saturation.
  - Saturation is sticky: once item_count reaches its cap, further items do not increment it.
  - sale_count saturates independently.
- Reset mid-transaction (any state, including ALARM): immediate return to reset values and no txn_done pulse. A pending alarm is discarded.
- clear_alarm outside ALARM: no effect. Held-high clear_alarm on entry to ALARM releases after one ALARM cycle; minimum alarm=1 duration is 1 cycle.

Test Plan:
1. Reset mid-operation → all outputs 0 immediately (async), item_ready=1 after deassert.
2. IDLE, scan upc=3'b010 mark=0 (sale), then 3'b001 mark=1 (normal), then checkout → item_count=2, sale_count=1; txn_done high exactly one cycle; next cycle IDLE with busy=0 and counts still 2/1.
3. In SCAN with 1 item counted, scan upc=3'b100 mark=0 (stolen) → alarm=1 and item_ready=0 next cycle, item_count stays 1. checkout while in ALARM has no effect. clear_alarm → alarm=0, state SCAN, item_count=1.
4. Same cycle stolen accept (upc=3'b000, mark=0) and checkout=1 → ALARM entered, no txn_done. After clear_alarm plus a second checkout → txn_done, item_count unchanged.
5. CW=2: accept 5 items upc=3'b011 mark=1 (sale) → item_count=3, sale_count=3, no wraparound. Checkout → txn_done.
6. After a transaction closes with counts 2/1, accept in IDLE upc=3'b000 mark=1 (normal) → item_count=1, sale_count=0, busy=1.

Source files
------------

// File: rtl/upc_checkout_ctrl.sv
// Checkout-lane sequencer: classifies scanned items (sale/stolen/normal),
// keeps saturating per-transaction counts, latches an alarm on a stolen item
// until an attendant clears it, and closes the transaction on checkout.
module upc_checkout_ctrl #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          item_valid,
    input  logic [2:0]    upc,
    input  logic          mark,
    output logic          item_ready,
    input  logic          checkout,
    input  logic          clear_alarm,
    output logic [CW-1:0] item_count,
    output logic [CW-1:0] sale_count,
    output logic          alarm,
    output logic          busy,
    output logic          txn_done
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ALARM, S_DONE} state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        r_state;
    logic          r_ready;
    logic          r_alarm;
    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_item_count;
    logic [CW-1:0] r_sale_count;

    logic          w_accept;
    logic          w_sale;
    logic          w_stolen;
    logic [CW-1:0] w_item_inc;
    logic [CW-1:0] w_sale_inc;

    // Classification and saturating increments for the item presented this cycle.
    // Ready comes from a register, so valid never feeds back into ready.
    assign w_accept   = item_valid & r_ready;
    assign w_sale     = upc[1] | (upc[2] & upc[0]);
    assign w_stolen   = ~mark & ~upc[1] & (upc[2] | ~upc[0]);
    assign w_item_inc = (r_item_count == CNT_MAX) ? r_item_count : r_item_count + CNT_ONE;
    assign w_sale_inc = (w_sale && r_sale_count != CNT_MAX) ? r_sale_count + CNT_ONE
                                                             : r_sale_count;

    // Lane sequencer: state, counts and all status outputs registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_alarm      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_item_count <= '0;
            r_sale_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        if (w_stolen) begin
                            r_item_count <= '0;
                            r_sale_count <= '0;
                            r_alarm      <= 1'b1;
                            r_ready      <= 1'b0;
                            r_state      <= S_ALARM;
                        end else begin
                            r_item_count <= CNT_ONE;
                            r_sale_count <= CW'(w_sale);
                            r_state      <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    // A stolen accept beats a same-cycle checkout.
                    if (w_accept && w_stolen) begin
                        r_alarm <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= S_ALARM;
                    end else begin
                        if (w_accept) begin
                            r_item_count <= w_item_inc;
                            r_sale_count <= w_sale_inc;
                        end
                        if (checkout) begin
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ALARM: begin
                    if (clear_alarm) begin
                        r_alarm <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign item_ready = r_ready;
    assign alarm      = r_alarm;
    assign busy       = r_busy;
    assign txn_done   = r_done;
    assign item_count = r_item_count;
    assign sale_count = r_sale_count;

endmodule

// File: tb/tb_upc_checkout_ctrl.sv
// Directed bench for upc_checkout_ctrl: a vector table for the main flow plus
// hand-written sequences for async reset and counter saturation (CW=2 instance).
module tb_upc_checkout_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       item_valid, mark, checkout, clear_alarm;
    logic [2:0] upc;
    logic       item_ready, alarm, busy, txn_done;
    logic [7:0] item_count, sale_count;

    logic       v2_valid, v2_mark, v2_co, v2_clr;
    logic [2:0] v2_upc;
    logic       r2_ready, r2_alarm, r2_busy, r2_done;
    logic [1:0] r2_cnt, r2_sale;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    upc_checkout_ctrl #(.CW(8)) dut (
        .clk(clk), .reset(reset), .item_valid(item_valid), .upc(upc), .mark(mark),
        .item_ready(item_ready), .checkout(checkout), .clear_alarm(clear_alarm),
        .item_count(item_count), .sale_count(sale_count), .alarm(alarm),
        .busy(busy), .txn_done(txn_done)
    );

    upc_checkout_ctrl #(.CW(2)) dut2 (
        .clk(clk), .reset(reset), .item_valid(v2_valid), .upc(v2_upc), .mark(v2_mark),
        .item_ready(r2_ready), .checkout(v2_co), .clear_alarm(v2_clr),
        .item_count(r2_cnt), .sale_count(r2_sale), .alarm(r2_alarm),
        .busy(r2_busy), .txn_done(r2_done)
    );

    typedef struct {
        logic       valid;
        logic [2:0] upc;
        logic       mark;
        logic       co;
        logic       clr;
        logic       e_rdy;
        logic [7:0] e_cnt;
        logic [7:0] e_sale;
        logic       e_alarm;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(logic v, logic [2:0] u, logic m, logic co, logic clr,
                                logic rdy, logic [7:0] cnt, logic [7:0] sl,
                                logic al, logic bz, logic dn);
        vec_t t;
        t.valid = v; t.upc = u; t.mark = m; t.co = co; t.clr = clr;
        t.e_rdy = rdy; t.e_cnt = cnt; t.e_sale = sl;
        t.e_alarm = al; t.e_busy = bz; t.e_done = dn;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_main(input int idx, input logic rdy, input logic [7:0] cnt,
                            input logic [7:0] sl, input logic al, input logic bz,
                            input logic dn);
        chk("item_ready", idx, 32'(item_ready), 32'(rdy));
        chk("item_count", idx, 32'(item_count), 32'(cnt));
        chk("sale_count", idx, 32'(sale_count), 32'(sl));
        chk("alarm",      idx, 32'(alarm),      32'(al));
        chk("busy",       idx, 32'(busy),       32'(bz));
        chk("txn_done",   idx, 32'(txn_done),   32'(dn));
    endtask

    task automatic drive(input logic v, input logic [2:0] u, input logic m,
                         input logic co, input logic clr);
        item_valid = v; upc = u; mark = m; checkout = co; clear_alarm = clr;
    endtask

    task automatic drive2(input logic v, input logic [2:0] u, input logic m,
                          input logic co);
        v2_valid = v; v2_upc = u; v2_mark = m; v2_co = co; v2_clr = 1'b0;
    endtask

    task automatic chk2(input int idx, input logic [1:0] cnt, input logic [1:0] sl,
                        input logic bz, input logic dn);
        chk("cw2_item_count", idx, 32'(r2_cnt),  32'(cnt));
        chk("cw2_sale_count", idx, 32'(r2_sale), 32'(sl));
        chk("cw2_busy",       idx, 32'(r2_busy), 32'(bz));
        chk("cw2_txn_done",   idx, 32'(r2_done), 32'(dn));
    endtask

    initial begin
        //         valid upc    mark co clr | rdy cnt sale alarm busy done
        vt[0]  = mk(1, 3'b010, 0, 0, 0,   1, 1, 1, 0, 1, 0); // sale item opens txn
        vt[1]  = mk(1, 3'b001, 1, 0, 0,   1, 2, 1, 0, 1, 0); // normal item
        vt[2]  = mk(0, 3'b000, 0, 1, 0,   0, 2, 1, 0, 0, 1); // checkout -> DONE
        vt[3]  = mk(0, 3'b000, 0, 0, 0,   1, 2, 1, 0, 0, 0); // IDLE, counts kept
        vt[4]  = mk(1, 3'b000, 1, 0, 0,   1, 1, 0, 0, 1, 0); // new txn, normal
        vt[5]  = mk(1, 3'b100, 0, 0, 0,   0, 1, 0, 1, 1, 0); // stolen -> ALARM
        vt[6]  = mk(1, 3'b010, 1, 1, 0,   0, 1, 0, 1, 1, 0); // checkout/valid ignored
        vt[7]  = mk(0, 3'b000, 0, 0, 1,   1, 1, 0, 0, 1, 0); // clear -> SCAN
        vt[8]  = mk(1, 3'b000, 0, 1, 0,   0, 1, 0, 1, 1, 0); // stolen beats checkout
        vt[9]  = mk(0, 3'b000, 0, 0, 1,   1, 1, 0, 0, 1, 0); // clear
        vt[10] = mk(0, 3'b000, 0, 1, 0,   0, 1, 0, 0, 0, 1); // checkout -> DONE
        vt[11] = mk(0, 3'b000, 0, 0, 0,   1, 1, 0, 0, 0, 0); // IDLE
        vt[12] = mk(0, 3'b000, 0, 1, 1,   1, 1, 0, 0, 0, 0); // co/clr ignored in IDLE
        vt[13] = mk(1, 3'b100, 0, 0, 1,   0, 0, 0, 1, 1, 0); // stolen from IDLE, clr held
        vt[14] = mk(0, 3'b000, 0, 0, 1,   1, 0, 0, 0, 1, 0); // held clr releases after 1
        vt[15] = mk(1, 3'b011, 1, 1, 0,   0, 1, 1, 0, 0, 1); // item counted, then DONE
        vt[16] = mk(0, 3'b000, 0, 0, 0,   1, 1, 1, 0, 0, 0); // IDLE

        reset = 1'b1;
        drive(0, 3'b000, 0, 0, 0);
        drive2(0, 3'b000, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_main(-1, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", -1, 32'(item_ready), 32'd1);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vt[i].valid, vt[i].upc, vt[i].mark, vt[i].co, vt[i].clr);
            @(posedge clk); #1;
            chk_main(i, vt[i].e_rdy, vt[i].e_cnt, vt[i].e_sale,
                     vt[i].e_alarm, vt[i].e_busy, vt[i].e_done);
        end

        // Async reset while in ALARM: outputs clear before any clock edge.
        @(negedge clk) drive(1, 3'b010, 0, 0, 0);
        @(posedge clk); #1;
        chk("pre_rst_cnt", 100, 32'(item_count), 32'd1);
        @(negedge clk) drive(1, 3'b101, 0, 0, 0);
        @(posedge clk); #1;
        chk("pre_rst_alarm", 101, 32'(alarm), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_main(102, item_ready, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) drive(0, 3'b000, 0, 0, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        chk_main(103, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        // CW=2: five sale items saturate both counts at 3.
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk) drive2(1, 3'b011, 1, 0);
            @(posedge clk); #1;
            chk2(200 + k, (k > 3) ? 2'd3 : 2'(k), (k > 3) ? 2'd3 : 2'(k), 1'b1, 1'b0);
        end
        @(negedge clk) drive2(0, 3'b000, 0, 1);
        @(posedge clk); #1;
        chk2(210, 2'd3, 2'd3, 1'b0, 1'b1);
        @(negedge clk) drive2(0, 3'b000, 0, 0);
        @(posedge clk); #1;
        chk2(211, 2'd3, 2'd3, 1'b0, 1'b0);

        // CW=2: item count saturates first; sale count keeps climbing on its own.
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk) drive2(1, 3'b001, 1, 0);
            @(posedge clk); #1;
            chk2(220 + k, (k > 3) ? 2'd3 : 2'(k), 2'd0, 1'b1, 1'b0);
        end
        @(negedge clk) drive2(1, 3'b010, 1, 0);
        @(posedge clk); #1;
        chk2(230, 2'd3, 2'd1, 1'b1, 1'b0);
        @(negedge clk) drive2(0, 3'b000, 0, 1);
        @(posedge clk); #1;
        chk2(231, 2'd3, 2'd1, 1'b0, 1'b1);
        @(negedge clk) drive2(0, 3'b000, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
